// File: rtl/ysyx_220066_wb_unit_if.sv
// Write-back stage bus: MEM-stage entry handshake, memory response, regfile write port and commit record.
// "master" is the MEM/memory side, "slave" is the write-back unit.
interface ysyx_220066_wb_unit_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned RA_W = 5,
    parameter int unsigned PC_W = 64
);
    localparam int unsigned LANE_W = $clog2(XLEN / 8);

    logic              in_valid;
    logic              in_ready;
    logic              in_wen;
    logic [RA_W-1:0]   in_rd;
    logic [XLEN-1:0]   in_data;
    logic [PC_W-1:0]   in_nxtpc;
    logic              in_mem_rd;
    logic              in_mem_wr;
    logic [2:0]        in_memop;
    logic [LANE_W-1:0] in_addr_low;
    logic              in_error;
    logic              in_done;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_error;
    logic              rf_wen;
    logic [RA_W-1:0]   rf_rd;
    logic [XLEN-1:0]   rf_wdata;
    logic              commit_valid;
    logic [PC_W-1:0]   commit_pc;
    logic              commit_error;
    logic              commit_done;

    modport master (
        output in_valid, in_wen, in_rd, in_data, in_nxtpc, in_mem_rd, in_mem_wr,
               in_memop, in_addr_low, in_error, in_done, mem_rvalid, mem_rdata, mem_error,
        input  in_ready, rf_wen, rf_rd, rf_wdata, commit_valid, commit_pc, commit_error, commit_done
    );

    modport slave (
        input  in_valid, in_wen, in_rd, in_data, in_nxtpc, in_mem_rd, in_mem_wr,
               in_memop, in_addr_low, in_error, in_done, mem_rvalid, mem_rdata, mem_error,
        output in_ready, rf_wen, rf_rd, rf_wdata, commit_valid, commit_pc, commit_error, commit_done
    );
endinterface

// File: rtl/ysyx_220066_wb_unit.sv
// Write-back stage: one-entry holding register that waits for memory responses on loads/stores,
// extends load data, flags misalignment and timeouts, and drives the regfile port and commit record.
module ysyx_220066_wb_unit #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned RA_W    = 5,
    parameter int unsigned PC_W    = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_220066_wb_unit_if.slave  bus
);
    localparam int unsigned LANE_W = $clog2(XLEN / 8);
    localparam int unsigned IDX_W  = $clog2(XLEN);
    localparam int unsigned NB_W   = IDX_W + 1;
    localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_EMPTY, S_FULL, S_WAIT} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_wen;
    logic [RA_W-1:0]   r_rd;
    logic [XLEN-1:0]   r_data;
    logic [PC_W-1:0]   r_nxtpc;
    logic              r_mem_rd;
    logic [2:0]        r_memop;
    logic [LANE_W-1:0] r_addr;
    logic              r_err;
    logic              r_done;
    logic              r_misalign;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_in_mem;
    logic              w_in_misalign;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_retire;
    logic              w_resp;
    logic              w_tmo_hit;
    logic              w_err;
    logic [LANE_W-1:0] w_mask;
    logic [LANE_W-1:0] w_base;
    logic [XLEN-1:0]   w_shifted;
    logic [NB_W-1:0]   w_nbits;
    logic [XLEN-1:0]   w_keep;
    logic              w_sign;
    logic [XLEN-1:0]   w_ext;

    // Sizes wider than the word can never be aligned.
    function automatic logic misalign_f(input logic [1:0] size, input logic [LANE_W-1:0] a);
        logic [LANE_W-1:0] mask;
        mask = LANE_W'((32'd1 << size) - 32'd1);
        return (32'(size) > LANE_W) || ((a & mask) != '0);
    endfunction

    assign w_in_mem      = bus.in_mem_rd | bus.in_mem_wr;
    assign w_in_misalign = w_in_mem & misalign_f(bus.in_memop[1:0], bus.in_addr_low);

    // Next-state and handshake; a response arriving on the timeout cycle wins.
    always_comb begin
        w_state_nxt = r_state;
        w_resp      = 1'b0;
        w_tmo_hit   = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            S_FULL: w_retire = 1'b1;
            S_WAIT: begin
                w_resp    = bus.mem_rvalid;
                w_tmo_hit = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT));
                w_retire  = w_resp | w_tmo_hit;
            end
            default: ;
        endcase
        w_in_ready = (r_state == S_EMPTY) | w_retire;
        w_accept   = bus.in_valid & w_in_ready;
        if (w_accept) begin
            w_state_nxt = (w_in_mem & ~bus.in_error & ~w_in_misalign) ? S_WAIT : S_FULL;
        end else if (w_retire) begin
            w_state_nxt = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_EMPTY;
        else     r_state <= w_state_nxt;
    end

    // Held entry and saturating wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen      <= 1'b0;
            r_rd       <= '0;
            r_data     <= '0;
            r_nxtpc    <= '0;
            r_mem_rd   <= 1'b0;
            r_memop    <= '0;
            r_addr     <= '0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_wen      <= bus.in_wen;
            r_rd       <= bus.in_rd;
            r_data     <= bus.in_data;
            r_nxtpc    <= bus.in_nxtpc;
            r_mem_rd   <= bus.in_mem_rd;
            r_memop    <= bus.in_memop;
            r_addr     <= bus.in_addr_low;
            r_err      <= bus.in_error;
            r_done     <= bus.in_done;
            r_misalign <= w_in_misalign;
            r_cnt      <= '0;
        end else if (r_state == S_WAIT && r_cnt != '1) begin
            r_cnt      <= r_cnt + CNT_W'(1);
        end
    end

    // Load lane select and sign/zero extension from the held size and offset.
    always_comb begin
        w_mask    = LANE_W'((32'd1 << r_memop[1:0]) - 32'd1);
        w_base    = r_addr & ~w_mask;
        w_shifted = bus.mem_rdata >> {w_base, 3'b000};
        w_nbits   = (32'(r_memop[1:0]) >= LANE_W) ? NB_W'(XLEN) : (NB_W'(8) << r_memop[1:0]);
        w_keep    = (w_nbits == NB_W'(XLEN)) ? '1 : ((XLEN'(1) << w_nbits) - XLEN'(1));
        w_sign    = w_shifted[IDX_W'(w_nbits - NB_W'(1))] & ~r_memop[2];
        w_ext     = (w_shifted & w_keep) | ({XLEN{w_sign}} & ~w_keep);
    end

    assign w_err = r_err | r_misalign | (w_resp & bus.mem_error) | (w_tmo_hit & ~w_resp);

    assign bus.in_ready     = w_in_ready;
    assign bus.rf_wen       = w_retire & r_wen & (r_rd != '0) & ~w_err;
    assign bus.rf_rd        = w_retire ? r_rd : '0;
    assign bus.rf_wdata     = w_retire ? (r_mem_rd ? w_ext : r_data) : '0;
    assign bus.commit_valid = w_retire;
    assign bus.commit_pc    = w_retire ? r_nxtpc : '0;
    assign bus.commit_error = w_retire & w_err;
    assign bus.commit_done  = w_retire & r_done;
endmodule

// File: tb/tb_ysyx_220066_wb_unit.sv
// Bench for ysyx_220066_wb_unit: table of entries with scoreboarded commits on a 64-bit unit,
// plus hand sequences for back-to-back, reset and a 32-bit unit with a short timeout.
module tb_ysyx_220066_wb_unit;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    ysyx_220066_wb_unit_if #(.XLEN(64), .RA_W(5), .PC_W(64)) ifa ();
    ysyx_220066_wb_unit_if #(.XLEN(32), .RA_W(5), .PC_W(64)) ifb ();

    ysyx_220066_wb_unit #(.XLEN(64), .RA_W(5), .PC_W(64), .TIMEOUT(8)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa.slave)
    );

    ysyx_220066_wb_unit #(.XLEN(32), .RA_W(5), .PC_W(64), .TIMEOUT(4)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb.slave)
    );

    typedef struct packed {
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] wdata;
        logic [63:0] pc;
        logic        err;
        logic        done;
    } cmt_t;

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [63:0] pc;
        logic        mrd;
        logic        mwr;
        logic [2:0]  op;
        logic [2:0]  a;
        logic        err;
        logic        done;
        int          dly;    // response delay in wait cycles; -1 = entry never waits
        logic [63:0] rdata;
        logic        merr;
        logic        x_wen;
        logic [63:0] x_wdata;
        logic        x_err;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl[NV];
    cmt_t sb[$];
    cmt_t m_got;
    cmt_t m_exp;

    function automatic vec_t mk(input logic wen, input logic [4:0] rd, input logic [63:0] data,
                                input logic mrd, input logic mwr, input logic [2:0] op,
                                input logic [2:0] a, input logic err, input logic done,
                                input int dly, input logic [63:0] rdata, input logic merr,
                                input logic x_wen, input logic [63:0] x_wdata, input logic x_err);
        vec_t v;
        v.wen = wen; v.rd = rd; v.data = data; v.pc = '0; v.mrd = mrd; v.mwr = mwr;
        v.op = op; v.a = a; v.err = err; v.done = done; v.dly = dly; v.rdata = rdata;
        v.merr = merr; v.x_wen = x_wen; v.x_wdata = x_wdata; v.x_err = x_err;
        return v;
    endfunction

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endfunction

    // Commit monitor for the 64-bit unit: pops the scoreboard on every commit, expects all-zero outputs otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ifa.commit_valid) begin
                m_got = '{ifa.rf_wen, ifa.rf_rd, ifa.rf_wdata, ifa.commit_pc, ifa.commit_error, ifa.commit_done};
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL commit_a: unexpected commit pc=%h, expected no commit", ifa.commit_pc);
                end else begin
                    m_exp = sb.pop_front();
                    if (m_got !== m_exp) begin
                        n_bad++;
                        $display("FAIL commit_a: got wen=%b rd=%0d wdata=%h pc=%h err=%b done=%b, expected wen=%b rd=%0d wdata=%h pc=%h err=%b done=%b",
                                 m_got.wen, m_got.rd, m_got.wdata, m_got.pc, m_got.err, m_got.done,
                                 m_exp.wen, m_exp.rd, m_exp.wdata, m_exp.pc, m_exp.err, m_exp.done);
                    end
                end
            end else begin
                chk("idle_a", 64'(ifa.rf_wen | ifa.commit_error | ifa.commit_done | (|ifa.rf_rd)
                                  | (|ifa.rf_wdata) | (|ifa.commit_pc)), 64'd0);
            end
        end
    end

    task automatic drv_a(input vec_t v, input bit push, output int waits);
        bit acc;
        acc   = 1'b0;
        waits = 0;
        ifa.in_valid = 1'b1;   ifa.in_wen = v.wen;      ifa.in_rd = v.rd;
        ifa.in_data = v.data;  ifa.in_nxtpc = v.pc;     ifa.in_mem_rd = v.mrd;
        ifa.in_mem_wr = v.mwr; ifa.in_memop = v.op;     ifa.in_addr_low = v.a;
        ifa.in_error = v.err;  ifa.in_done = v.done;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            acc = ifa.in_ready;
            if (!acc) waits++;
            @(posedge clk); #1;
        end
        if (!acc) begin
            n_vec++; n_bad++;
            $display("FAIL accept_a: rd=%0d in_ready low for 40 cycles, expected acceptance", v.rd);
        end else if (push) begin
            sb.push_back('{v.x_wen, v.rd, v.x_wdata, v.pc, v.x_err, v.done});
        end
    endtask

    task automatic set_b(input logic [4:0] rd, input logic [2:0] op, input logic [1:0] a);
        ifb.in_wen = 1'b1;     ifb.in_rd = rd;         ifb.in_data = '0;
        ifb.in_nxtpc = 64'h40; ifb.in_mem_rd = 1'b1;   ifb.in_mem_wr = 1'b0;
        ifb.in_memop = op;     ifb.in_addr_low = a;    ifb.in_error = 1'b0;
        ifb.in_done = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   w;

        ifa.in_valid = 0; ifa.in_wen = 0; ifa.in_rd = 0; ifa.in_data = 0; ifa.in_nxtpc = 0;
        ifa.in_mem_rd = 0; ifa.in_mem_wr = 0; ifa.in_memop = 0; ifa.in_addr_low = 0;
        ifa.in_error = 0; ifa.in_done = 0; ifa.mem_rvalid = 0; ifa.mem_rdata = 0; ifa.mem_error = 0;
        ifb.in_valid = 0; ifb.in_wen = 0; ifb.in_rd = 0; ifb.in_data = 0; ifb.in_nxtpc = 0;
        ifb.in_mem_rd = 0; ifb.in_mem_wr = 0; ifb.in_memop = 0; ifb.in_addr_low = 0;
        ifb.in_error = 0; ifb.in_done = 0; ifb.mem_rvalid = 0; ifb.mem_rdata = 0; ifb.mem_error = 0;

        //           wen rd  data      mrd mwr op    a     err done dly rdata                    merr xw  xwdata                   xerr
        tbl[0]  = mk(1, 5,  64'h1234, 0, 0, 3'd0, 3'd0, 0, 0, -1, 64'h0,                   0,   1, 64'h1234,                 0);
        tbl[1]  = mk(1, 0,  64'h55,   0, 0, 3'd0, 3'd0, 0, 0, -1, 64'h0,                   0,   0, 64'h55,                   0);
        tbl[2]  = mk(1, 10, 64'h0,    1, 0, 3'd0, 3'd3, 0, 0,  4, 64'h1122_3344_80CC_BBAA, 0,   1, 64'hFFFF_FFFF_FFFF_FF80, 0);
        tbl[3]  = mk(1, 10, 64'h0,    1, 0, 3'd4, 3'd3, 0, 0,  4, 64'h1122_3344_80CC_BBAA, 0,   1, 64'h80,                   0);
        tbl[4]  = mk(1, 11, 64'h0,    1, 0, 3'd1, 3'd6, 0, 0,  0, 64'h8765_4321_0000_0000, 0,   1, 64'hFFFF_FFFF_FFFF_8765, 0);
        tbl[5]  = mk(1, 12, 64'h0,    1, 0, 3'd6, 3'd4, 0, 0,  2, 64'hDEAD_BEEF_0000_0000, 0,   1, 64'h0000_0000_DEAD_BEEF, 0);
        tbl[6]  = mk(1, 13, 64'h0,    1, 0, 3'd2, 3'd4, 0, 0,  1, 64'hDEAD_BEEF_0000_0000, 0,   1, 64'hFFFF_FFFF_DEAD_BEEF, 0);
        tbl[7]  = mk(1, 14, 64'h0,    1, 0, 3'd3, 3'd0, 0, 0,  3, 64'h0123_4567_89AB_CDEF, 0,   1, 64'h0123_4567_89AB_CDEF, 0);
        tbl[8]  = mk(1, 15, 64'h0,    1, 0, 3'd2, 3'd2, 0, 0, -1, 64'h0000_0000_8000_0000, 0,   0, 64'hFFFF_FFFF_8000_0000, 1);
        tbl[9]  = mk(0, 0,  64'h77,   0, 1, 3'd2, 3'd0, 0, 0,  1, 64'h0,                   1,   0, 64'h77,                   1);
        tbl[10] = mk(1, 7,  64'h0,    1, 0, 3'd0, 3'd0, 1, 0, -1, 64'h7F,                  0,   0, 64'h7F,                   1);
        tbl[11] = mk(1, 3,  64'h9,    0, 0, 3'd0, 3'd0, 0, 1, -1, 64'h0,                   0,   1, 64'h9,                    0);
        tbl[12] = mk(1, 16, 64'h0,    1, 0, 3'd1, 3'd1, 0, 0, -1, 64'hFFFF,                0,   0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        tbl[13] = mk(1, 8,  64'h0,    1, 0, 3'd0, 3'd0, 0, 0,  1, 64'h01,                  1,   0, 64'h01,                   1);
        tbl[14] = mk(1, 9,  64'h0,    1, 0, 3'd5, 3'd2, 0, 0,  0, 64'h0000_0000_9ABC_0000, 0,   1, 64'h9ABC,                 0);
        tbl[15] = mk(1, 17, 64'h0,    1, 0, 3'd0, 3'd7, 0, 0,  2, 64'hF000_0000_0000_0000, 0,   1, 64'hFFFF_FFFF_FFFF_FFF0, 0);

        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        chk("reset_ready_a", 64'(ifa.in_ready), 64'd1);
        chk("reset_commit_a", 64'(ifa.commit_valid), 64'd0);
        chk("reset_ready_b", 64'(ifb.in_ready), 64'd1);
        chk("reset_commit_b", 64'(ifb.commit_valid), 64'd0);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Table: drive each entry, answer memory after its delay, expect in_ready low while waiting.
        for (int i = 0; i < NV; i++) begin
            v = tbl[i];
            v.pc = 64'h8000_0000 + 64'(i * 4);
            ifa.mem_rdata  = v.rdata;
            ifa.mem_error  = v.merr;
            ifa.mem_rvalid = 1'b0;
            drv_a(v, 1'b1, w);
            ifa.in_valid = 1'b0;
            if (v.dly >= 0) begin
                for (int k = 0; k < v.dly; k++) begin
                    @(negedge clk);
                    chk("stall_a", 64'(ifa.in_ready), 64'd0);
                    @(posedge clk); #1;
                end
                ifa.mem_rvalid = 1'b1;
                @(posedge clk); #1;
                ifa.mem_rvalid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        ifa.mem_error = 1'b0;

        // Back-to-back ALU entries: each accepted without waiting, one commit per cycle.
        for (int j = 0; j < 3; j++) begin
            v = mk(1, 5'(20 + j), 64'(256 + j), 0, 0, 3'd0, 3'd0, 0, 0, -1, 64'h0, 0, 1, 64'(256 + j), 0);
            v.pc = 64'h9000 + 64'(j * 4);
            drv_a(v, 1'b1, w);
            if (j > 0) chk("b2b_no_bubble", 64'(w), 64'd0);
        end
        ifa.in_valid = 1'b0;
        @(posedge clk); #1;

        // Reset while waiting on memory: the late response must be ignored.
        v = mk(1, 9, 64'h0, 1, 0, 3'd0, 3'd0, 0, 0, 5, 64'hAA, 0, 1, 64'h0, 0);
        drv_a(v, 1'b0, w);
        ifa.in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_wait_stall", 64'(ifa.in_ready), 64'd0);
            @(posedge clk); #1;
        end
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        ifa.mem_rvalid = 1'b1;
        @(negedge clk);
        chk("rst_drop_ready", 64'(ifa.in_ready), 64'd1);
        chk("rst_drop_commit", 64'(ifa.commit_valid), 64'd0);
        @(posedge clk); #1;
        ifa.mem_rvalid = 1'b0;

        // Reset takes priority over a capture on the same edge.
        ifa.in_mem_rd = 1'b0; ifa.in_wen = 1'b1; ifa.in_rd = 5'd5; ifa.in_data = 64'h33;
        ifa.in_valid = 1'b1;
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        ifa.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_over_capture", 64'(ifa.commit_valid), 64'd0);
        @(posedge clk); #1;

        // 32-bit unit: doubleword access faults immediately.
        set_b(5'd4, 3'd3, 2'd0);
        ifb.in_valid = 1'b1;
        @(negedge clk);
        chk("b_ready", 64'(ifb.in_ready), 64'd1);
        @(posedge clk); #1;
        ifb.in_valid = 1'b0;
        @(negedge clk);
        chk("ld32_fault", 64'({ifb.commit_valid, ifb.commit_error, ifb.rf_wen}), 64'b110);
        @(posedge clk); #1;

        // Timeout=4: counter starts at 0 on entry, so it hits after four stalled cycles.
        set_b(5'd6, 3'd2, 2'd0);
        ifb.in_valid = 1'b1;
        @(posedge clk); #1;
        ifb.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("tmo_wait", 64'({ifb.in_ready, ifb.commit_valid}), 64'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("tmo_commit", 64'({ifb.commit_valid, ifb.commit_error, ifb.rf_wen, ifb.in_ready}), 64'b1101);
        @(posedge clk); #1;

        // Response on the timeout cycle wins: data written, no error.
        set_b(5'd6, 3'd2, 2'd0);
        ifb.in_valid = 1'b1;
        @(posedge clk); #1;
        ifb.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("race_wait", 64'({ifb.in_ready, ifb.commit_valid}), 64'd0);
            @(posedge clk); #1;
        end
        ifb.mem_rvalid = 1'b1;
        ifb.mem_rdata  = 32'h8000_0001;
        @(negedge clk);
        chk("race_commit", 64'({ifb.commit_valid, ifb.commit_error, ifb.rf_wen}), 64'b101);
        chk("race_wdata", 64'(ifb.rf_wdata), 64'h8000_0001);
        @(posedge clk); #1;
        ifb.mem_rvalid = 1'b0;
        @(negedge clk);
        chk("b_idle", 64'(ifb.commit_valid), 64'd0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
